// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 serial receiver feeding a small receive FIFO.
//
// Parameters
//   CLKS_PER_BIT : CLK cycles per serial bit (>= 4)
//   DEPTH        : FIFO entries (power of two, >= 2)
//
// Ports
//   CLK       : clock, all state updates on rising edge
//   RST_N     : asynchronous active-low reset
//   rx        : asynchronous serial input, idle high, LSB first
//   rd_ready  : consumer ready; a pop happens when rd_valid && rd_ready
//   rd_valid  : FIFO non-empty
//   rd_data   : FIFO head byte, 8'h00 when empty
//   overflow  : sticky, set when a received byte is dropped on a full FIFO
//   frame_err : sticky, set when a stop bit is sampled low
module uart_rx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned DEPTH        = 8
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       rx,
  input  logic       rd_ready,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       overflow,
  output logic       frame_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  // Two-flop synchronizer, reset to the idle line level.
  logic rx_m;
  logic rx_s;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // Receive FSM
  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          push;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
    end else begin
      if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= CNT_HALF;
          end
        end
        START: begin
          if (cnt == '0) begin
            if (!rx_s) begin
              state   <= DATA;
              cnt     <= CNT_FULL;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        DATA: begin
          if (cnt == '0) begin
            shreg[bit_idx] <= rx_s;
            cnt            <= CNT_FULL;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        STOP: begin
          if (cnt == '0) begin
            if (!rx_s) begin
              frame_err <= 1'b1;
            end
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // The byte is complete in shreg once the FSM reaches STOP, so the push
  // is decoded directly from the stop-bit sample point.
  assign push = (state == STOP) && (cnt == '0) && rx_s;

  // Receive FIFO
  logic [7:0]  mem [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic        empty;
  logic        full;
  logic        pop;
  logic        wr_en;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop   = !empty && rd_ready;
  // A full FIFO still accepts a byte when the head leaves on the same cycle.
  assign wr_en = push && (!full || pop);

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wptr[AW-1:0]] <= shreg;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      if (push && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  assign rd_valid = !empty;
  assign rd_data  = empty ? 8'h00 : mem[rptr[AW-1:0]];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed bench for uart_rx_fifo (CLKS_PER_BIT=16, DEPTH=4).
// Stimulus pushes expected bytes into a queue; a negedge monitor pops and
// compares whenever the DUT hands a byte over (rd_valid && rd_ready).
module tb_uart_rx_fifo;

  localparam int unsigned CPB = 16;
  localparam int unsigned DEP = 4;

  logic       CLK;
  logic       RST_N;
  logic       rx;
  logic       rd_ready;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       overflow;
  logic       frame_err;

  int unsigned n_checks;
  int unsigned n_pass;
  logic [7:0]  exp_q [$];

  uart_rx_fifo #(
    .CLKS_PER_BIT(CPB),
    .DEPTH       (DEP)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .rx       (rx),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .overflow (overflow),
    .frame_err(frame_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: every handover is compared against the scoreboard head.
  always @(negedge CLK) begin
    if (RST_N && rd_valid && rd_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL pop_unexpected: got %0h, expected no byte", rd_data);
      end else begin
        check("pop_data", {24'h0, rd_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  // Keeps the phase at one time unit after a rising edge.
  task automatic wait_clks(input int unsigned n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clks(CPB);
    end
    rx = stop_bit;
    wait_clks(CPB);
    rx = 1'b1;
    wait_clks(24);
  endtask

  task automatic drain(input int unsigned n);
    rd_ready = 1'b1;
    wait_clks(n);
    rd_ready = 1'b0;
    wait_clks(1);
  endtask

  task automatic check_drained(input string name);
    check({name, "_rd_valid"}, {31'h0, rd_valid}, 32'h0);
    check({name, "_rd_data"}, {24'h0, rd_data}, 32'h0);
    check({name, "_pending"}, exp_q.size(), 32'h0);
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    rx    = 1'b1;
    exp_q.delete();
    wait_clks(3);
    RST_N = 1'b1;
    wait_clks(3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rx       = 1'b1;
    rd_ready = 1'b0;
    RST_N    = 1'b0;
    wait_clks(3);

    // Reset state
    check("rst_rd_valid", {31'h0, rd_valid}, 32'h0);
    check("rst_rd_data", {24'h0, rd_data}, 32'h0);
    check("rst_overflow", {31'h0, overflow}, 32'h0);
    check("rst_frame_err", {31'h0, frame_err}, 32'h0);
    RST_N = 1'b1;
    wait_clks(3);

    // Single byte, then a one-cycle read pulse
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    check("b55_rd_valid", {31'h0, rd_valid}, 32'h1);
    check("b55_rd_data", {24'h0, rd_data}, 32'h55);
    rd_ready = 1'b1;
    wait_clks(1);
    rd_ready = 1'b0;
    check_drained("b55");

    // Five bytes into a four-entry FIFO: the fifth is dropped
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b1);
    end
    check("ovf_overflow", {31'h0, overflow}, 32'h1);
    check("ovf_head", {24'h0, rd_data}, 32'h01);
    drain(8);
    check_drained("ovf");
    check("ovf_sticky", {31'h0, overflow}, 32'h1);

    // Bad stop bit, then a good frame
    send_frame(8'hA3, 1'b0);
    check("ferr_frame_err", {31'h0, frame_err}, 32'h1);
    check("ferr_rd_valid", {31'h0, rd_valid}, 32'h0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    check("ferr_good_valid", {31'h0, rd_valid}, 32'h1);
    drain(3);
    check_drained("ferr");

    // Short start-bit glitch, then a good frame
    rx = 1'b0;
    wait_clks(4);
    rx = 1'b1;
    wait_clks(30);
    check("glitch_rd_valid", {31'h0, rd_valid}, 32'h0);
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1);
    drain(3);
    check_drained("glitch");

    // Reset in the middle of data bit 4 with a byte pending and flags set
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    check("pre_rst_rd_valid", {31'h0, rd_valid}, 32'h1);
    rx = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      wait_clks(CPB);
    end
    rx = 1'b1;
    wait_clks(CPB / 2);
    RST_N = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_rd_valid", {31'h0, rd_valid}, 32'h0);
    check("midrst_rd_data", {24'h0, rd_data}, 32'h0);
    check("midrst_overflow", {31'h0, overflow}, 32'h0);
    check("midrst_frame_err", {31'h0, frame_err}, 32'h0);
    wait_clks(3);
    RST_N = 1'b1;
    wait_clks(30);
    check("postrst_rd_valid", {31'h0, rd_valid}, 32'h0);
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1);
    drain(4);
    check_drained("postrst");

    // Full FIFO with a pop on exactly the push cycle of 0x99
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(8'(i * 8'h11));
      send_frame(8'(i * 8'h11), 1'b1);
    end
    exp_q.push_back(8'h99);
    // The push lands 155 rising edges after rx first goes low
    // (2 sync + 8 half-bit + 9 x 16 bit periods + 1).
    fork
      send_frame(8'h99, 1'b1);
      begin
        wait_clks(154);
        rd_ready = 1'b1;
        wait_clks(1);
        rd_ready = 1'b0;
      end
    join
    check("fullpp_overflow", {31'h0, overflow}, 32'h0);
    check("fullpp_head", {24'h0, rd_data}, 32'h22);
    drain(8);
    check_drained("fullpp");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
